pc_next_gen: RTL and testbench

Next-PC sequencer for the 64-bit pipelined core. It sits on the input side of the PC register and drives that register's 64-bit `d` bus every cycle. It selects among reset vector, hold (stall), sequential `pc + 4`, and EX-stage branch redirect. It also owns the wrong-path flush window that follows a redirect.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_incr.sv | 12 +
 rtl/pc_next_gen.sv | 119 +++++++++++
 tb/tb_pc_next_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state type and default address constants.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_state_e;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [63:0] RESET_VECTOR = 64'h0;
    localparam logic [63:0] EXC_VECTOR   = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/pc_incr.sv
// Constant sequential-address adder (out = in + INSTR_BYTES), modulo 2^WIDTH.
module pc_incr #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned INSTR_BYTES = pc_pkg::INSTR_BYTES
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = in + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC sequencer: reset vector, stall hold, sequential fetch or EX redirect, plus the flush window.
// Optional misaligned-redirect trap is built when PC_ALIGN_CHECK_EN is defined.
module pc_next_gen #(
    parameter int unsigned      WIDTH        = 64,
    parameter int unsigned      INSTR_BYTES  = pc_pkg::INSTR_BYTES,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(pc_pkg::RESET_VECTOR),
    parameter int unsigned      FLUSH_CYCLES = 2
`ifdef PC_ALIGN_CHECK_EN
   ,parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(pc_pkg::EXC_VECTOR)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_cur,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc_next,
    output logic             flush,
    output logic             misalign_err
);

    // The redirect cycle is itself the first flush cycle, so the counter covers the rest.
    localparam logic [3:0] FCNT_LOAD   = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    pc_pkg::pc_state_e state, state_n;
    logic [3:0]        fcnt, fcnt_n;
    logic [WIDTH-1:0]  pc_seq;
    logic [WIDTH-1:0]  target_eff;

    pc_incr #(
        .WIDTH       (WIDTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_incr (
        .in  (pc_cur),
        .out (pc_seq)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= pc_pkg::BOOT;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        pc_next = pc_seq;
        flush   = 1'b0;
        if (reset) begin
            // Present BOOT outputs for the whole time reset is held, not just after the edge.
            pc_next = RESET_VECTOR;
            flush   = 1'b1;
        end else begin
            unique case (state)
                pc_pkg::BOOT: begin
                    pc_next = RESET_VECTOR;
                    flush   = 1'b1;
                    state_n = pc_pkg::RUN;
                end
                pc_pkg::RUN: begin
                    if (redirect_valid) begin
                        pc_next = target_eff;
                        flush   = 1'b1;
                        fcnt_n  = FCNT_LOAD;
                        state_n = MULTI_FLUSH ? pc_pkg::FLUSH : pc_pkg::RUN;
                    end else if (stall) begin
                        pc_next = pc_cur;
                    end
                end
                pc_pkg::FLUSH: begin
                    // Stall here comes from a wrong-path instruction and is ignored.
                    flush = 1'b1;
                    if (redirect_valid) begin
                        pc_next = target_eff;
                        fcnt_n  = FCNT_LOAD;
                    end else begin
                        fcnt_n = (fcnt == 4'd0) ? 4'd0 : fcnt - 4'd1;
                        if (fcnt <= 4'd1) state_n = pc_pkg::RUN;
                    end
                end
                default: begin
                    pc_next = RESET_VECTOR;
                    flush   = 1'b1;
                    state_n = pc_pkg::BOOT;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic take_redirect;
    logic err_q;

    assign misaligned    = (redirect_target[1:0] != 2'b00);
    assign target_eff    = misaligned ? EXC_VECTOR : redirect_target;
    assign take_redirect = redirect_valid && !reset &&
                           (state == pc_pkg::RUN || state == pc_pkg::FLUSH);

    always_ff @(posedge clk) begin
        if (reset)                           err_q <= 1'b0;
        else if (take_redirect && misaligned) err_q <= 1'b1;
    end

    assign misalign_err = err_q & ~reset;
`else
    assign target_eff   = redirect_target;
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_gen.sv
// Self-checking bench for pc_next_gen: directed scenarios plus random traffic against a
// flush-window reference model; PC_ALIGN_CHECK_EN enables the trap checks.
module tb_pc_next_gen;

    localparam int          F   = 2;
    localparam logic [63:0] RV  = 64'h0;
    localparam logic [63:0] EXC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_cur;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] pc_next;
    logic        flush;
    logic        misalign_err;

    pc_next_gen #(
        .WIDTH        (64),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_next         (pc_next),
        .flush           (flush),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a boot flag, remaining flush cycles, and the sticky error bit.
    bit          m_boot = 1'b1;
    int          m_left = 0;
    bit          m_err  = 1'b0;
    logic [63:0] exp_pc;
    logic        exp_fl;
    logic        exp_err;
    logic [63:0] obs_pc;
    logic        obs_fl;
    logic        obs_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] eff_target(input logic [63:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return (t[1:0] != 2'b00) ? EXC : t;
`else
        return t;
`endif
    endfunction

    task automatic predict();
        if (reset || m_boot) begin
            exp_pc = RV;
            exp_fl = 1'b1;
        end else if (redirect_valid) begin
            exp_pc = eff_target(redirect_target);
            exp_fl = 1'b1;
        end else if (m_left > 0) begin
            exp_pc = pc_cur + 64'd4;
            exp_fl = 1'b1;
        end else begin
            exp_pc = stall ? pc_cur : pc_cur + 64'd4;
            exp_fl = 1'b0;
        end
`ifdef PC_ALIGN_CHECK_EN
        exp_err = m_err && !reset;
`else
        exp_err = 1'b0;
`endif
    endtask

    task automatic advance();
        if (reset) begin
            m_boot = 1'b1;
            m_left = 0;
            m_err  = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (redirect_valid) begin
            m_left = F - 1;
            if (redirect_target[1:0] != 2'b00) m_err = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    // One clock: drive, sample mid-cycle, compare with model, then let the PC register follow.
    task automatic cycle(input logic r, input logic s, input logic rv,
                         input logic [63:0] tgt, input string tag);
        reset           = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(negedge clk);
        predict();
        obs_pc  = pc_next;
        obs_fl  = flush;
        obs_err = misalign_err;
        check({tag, ".pc"},    obs_pc,          exp_pc);
        check({tag, ".flush"}, 64'(obs_fl),     64'(exp_fl));
        check({tag, ".err"},   64'(obs_err),    64'(exp_err));
        @(posedge clk);
        advance();
        pc_cur = exp_pc;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        pc_cur          = '0;
        @(posedge clk);
        #1;

        // Reset for two cycles, one BOOT cycle, then sequential fetch.
        cycle(1'b1, 1'b0, 1'b0, '0, "rst0");
        check("rst0.flush_c", 64'(obs_fl), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, '0, "rst1");
        check("rst1.pc_c", obs_pc, RV);
        cycle(1'b0, 1'b0, 1'b0, '0, "boot");
        check("boot.pc_c", obs_pc, 64'h0);
        check("boot.flush_c", 64'(obs_fl), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, "seq");
            check("seq.pc_c", obs_pc, 64'(i * 4));
            check("seq.flush_c", 64'(obs_fl), 64'd0);
        end

        // Stall three cycles at 0x10.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, "stall");
            check("stall.pc_c", obs_pc, 64'h10);
            check("stall.flush_c", 64'(obs_fl), 64'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, "unstall");
        check("unstall.pc_c", obs_pc, 64'h14);

        // Redirect and stall together; stall in the flush cycle is ignored too.
        cycle(1'b0, 1'b1, 1'b1, 64'h400, "redir");
        check("redir.pc_c", obs_pc, 64'h400);
        check("redir.flush_c", 64'(obs_fl), 64'd1);
        cycle(1'b0, 1'b1, 1'b0, '0, "flush2");
        check("flush2.pc_c", obs_pc, 64'h404);
        check("flush2.flush_c", 64'(obs_fl), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, "post");
        check("post.pc_c", obs_pc, 64'h408);
        check("post.flush_c", 64'(obs_fl), 64'd0);

        // Address wrap.
        pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle(1'b0, 1'b0, 1'b0, '0, "wrap");
        check("wrap.pc_c", obs_pc, 64'h0);
        check("wrap.flush_c", 64'(obs_fl), 64'd0);

        // Reset on the second flush cycle abandons the window.
        cycle(1'b0, 1'b0, 1'b1, 64'h800, "redir2");
        cycle(1'b1, 1'b0, 1'b0, '0, "rstfl");
        check("rstfl.pc_c", obs_pc, RV);
        check("rstfl.flush_c", 64'(obs_fl), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, "boot2");
        check("boot2.flush_c", 64'(obs_fl), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, "run2");
        check("run2.pc_c", obs_pc, RV + 64'd4);
        check("run2.flush_c", 64'(obs_fl), 64'd0);

`ifdef PC_ALIGN_CHECK_EN
        cycle(1'b0, 1'b0, 1'b1, 64'h402, "mis");
        check("mis.pc_c", obs_pc, EXC);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, "sticky");
            check("sticky.err_c", 64'(obs_err), 64'd1);
        end
        cycle(1'b1, 1'b0, 1'b0, '0, "misrst");
        check("misrst.err_c", 64'(obs_err), 64'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic        r;
            logic        s;
            logic        rv;
            logic [63:0] t;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            t  = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 29) == 0)
                pc_cur = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
            cycle(r, s, rv, t, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
